// File: rtl/uart_rx_os.sv
// Oversampled UART receiver: 2-flop synchroniser, mid-bit start validation,
// runtime parity/stop config, one-entry valid/ready output with error flags.
module uart_rx_os #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample_tick,
  input  logic                  rx_in,
  input  logic [1:0]            parity_mode,
  input  logic                  stop_bits,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_par_err,
  output logic                  out_frm_err,
  output logic                  overrun,
  output logic                  busy
);
  localparam int OW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH+1);
  localparam logic [OW-1:0] OS_LAST  = OW'(OVERSAMPLE-1);
  localparam logic [OW-1:0] OS_MID   = OW'(OVERSAMPLE/2-1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH-1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic                  rx_meta, rx_s, armed;
  logic [2:0]            state;
  logic [OW-1:0]         os_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [1:0]            mode_l;
  logic                  stop2_l, stop_idx, par_err, frm_err;
  logic                  par_en, done, frm_now;

  assign par_en  = (mode_l == 2'b01) || (mode_l == 2'b10);
  assign done    = sample_tick && (state == ST_STOP) && (os_cnt == OS_LAST) &&
                   (!stop2_l || stop_idx);
  assign frm_now = frm_err | ~rx_s;
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      armed     <= 1'b0;
      os_cnt    <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      mode_l    <= 2'b00;
      stop2_l   <= 1'b0;
      stop_idx  <= 1'b0;
      par_err   <= 1'b0;
      frm_err   <= 1'b0;
    end else if (sample_tick) begin
      // Arming only while idle: a frame ending on a low stop bit must see
      // the line return high before another start is accepted.
      if (state == ST_IDLE && rx_s) armed <= 1'b1;
      case (state)
        ST_IDLE: if (!rx_s && armed) begin
          armed    <= 1'b0;
          os_cnt   <= '0;
          mode_l   <= parity_mode;
          stop2_l  <= stop_bits;
          stop_idx <= 1'b0;
          par_err  <= 1'b0;
          frm_err  <= 1'b0;
          state    <= ST_START;
        end
        ST_START: if (os_cnt == OS_MID) begin
          if (rx_s) state <= ST_IDLE;
          else begin
            os_cnt  <= '0;
            bit_cnt <= '0;
            state   <= ST_DATA;
          end
        end else os_cnt <= os_cnt + 1'b1;
        ST_DATA: if (os_cnt == OS_LAST) begin
          shift_reg <= {rx_s, shift_reg[DATA_WIDTH-1:1]};
          bit_cnt   <= bit_cnt + 1'b1;
          os_cnt    <= '0;
          if (bit_cnt == BIT_LAST) state <= par_en ? ST_PARITY : ST_STOP;
        end else os_cnt <= os_cnt + 1'b1;
        ST_PARITY: if (os_cnt == OS_LAST) begin
          par_err <= (rx_s ^ (^shift_reg)) ^ (mode_l == 2'b10);
          os_cnt  <= '0;
          state   <= ST_STOP;
        end else os_cnt <= os_cnt + 1'b1;
        ST_STOP: if (os_cnt == OS_LAST) begin
          os_cnt <= '0;
          if (!rx_s) frm_err <= 1'b1;
          if (stop2_l && !stop_idx) stop_idx <= 1'b1;
          else state <= ST_IDLE;
        end else os_cnt <= os_cnt + 1'b1;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_par_err <= 1'b0;
      out_frm_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        if (!out_valid || out_ready) begin
          out_data    <= shift_reg;
          out_par_err <= par_err;
          out_frm_err <= frm_now;
          out_valid   <= 1'b1;
        end else overrun <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: frames, parity, framing, break, false start,
// overrun, mid-frame reset and slow tick rate.
`timescale 1ns/1ps
module tb_uart_rx_os;
  logic       clk = 1'b0;
  logic       rst_n, sample_tick, rx_in, stop_bits, out_ready;
  logic [1:0] parity_mode;
  logic       out_valid, out_par_err, out_frm_err, overrun, busy;
  logic [7:0] out_data;

  int n_chk = 0, n_err = 0;
  int tick_div = 1;
  int vld_cyc = 0, n_ovr = 0;
  logic [9:0] q[$];   // {par_err, frm_err, data}

  uart_rx_os #(.DATA_WIDTH(8), .OVERSAMPLE(16)) dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .rx_in(rx_in),
    .parity_mode(parity_mode), .stop_bits(stop_bits), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_par_err(out_par_err),
    .out_frm_err(out_frm_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    int div_cnt;
    div_cnt = 0;
    sample_tick = 1'b0;
    forever begin
      @(negedge clk);
      div_cnt = (div_cnt + 1) % tick_div;
      sample_tick = (div_cnt == 0);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) q.push_back({out_par_err, out_frm_err, out_data});
      if (out_valid) vld_cyc++;
      if (overrun) n_ovr++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    int c;
    c = 0;
    while (c < n) begin
      @(posedge clk);
      if (sample_tick) c++;
    end
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx_in = b;
    wait_ticks(16);
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    wait_ticks(n);
  endtask

  // par < 0 means no parity bit on the wire
  task automatic send_frame(input logic [7:0] d, input int par, input int nstop, input logic s2);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (par >= 0) drive_bit(par[0]);
    drive_bit(1'b1);
    if (nstop == 2) drive_bit(s2);
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] d, input logic pe, input logic fe);
    logic [9:0] f;
    chk({tag, "_cnt"}, q.size(), 1);
    if (q.size() > 0) begin
      f = q.pop_front();
      chk({tag, "_data"}, f[7:0], d);
      chk({tag, "_par"}, f[9], pe);
      chk({tag, "_frm"}, f[8], fe);
    end
  endtask

  initial begin
    int c0;
    rst_n = 1'b0; rx_in = 1'b1; out_ready = 1'b1;
    parity_mode = 2'b00; stop_bits = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_par", out_par_err, 0);
    chk("rst_frm", out_frm_err, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    idle(32);

    // basic frame, one-cycle valid with ready high
    c0 = vld_cyc;
    send_frame(8'hA5, -1, 1, 1'b1);
    idle(20);
    expect_frame("a5", 8'hA5, 1'b0, 1'b0);
    chk("a5_vld_cyc", vld_cyc - c0, 1);
    chk("a5_busy", busy, 0);

    // parity
    parity_mode = 2'b01;
    send_frame(8'h03, 1, 1, 1'b1); idle(20);
    expect_frame("even_bad", 8'h03, 1'b1, 1'b0);
    send_frame(8'h03, 0, 1, 1'b1); idle(20);
    expect_frame("even_ok", 8'h03, 1'b0, 1'b0);
    parity_mode = 2'b10;
    send_frame(8'h03, 1, 1, 1'b1); idle(20);
    expect_frame("odd_ok", 8'h03, 1'b0, 1'b0);

    // two stops, second low, then a long break
    parity_mode = 2'b00; stop_bits = 1'b1;
    send_frame(8'h5A, -1, 2, 1'b0);
    wait_ticks(40 * 16);
    expect_frame("brk", 8'h5A, 1'b0, 1'b1);
    chk("brk_busy", busy, 0);
    idle(32);
    send_frame(8'h81, -1, 2, 1'b1); idle(20);
    expect_frame("after_brk", 8'h81, 1'b0, 1'b0);

    // false start
    stop_bits = 1'b0;
    rx_in = 1'b0; wait_ticks(4);
    rx_in = 1'b1; wait_ticks(2);
    chk("fs_busy_hi", busy, 1);
    wait_ticks(16);
    chk("fs_busy_lo", busy, 0);
    chk("fs_none", q.size(), 0);

    // overrun
    out_ready = 1'b0;
    c0 = n_ovr;
    send_frame(8'h11, -1, 1, 1'b1);
    send_frame(8'h22, -1, 1, 1'b1);
    idle(20);
    chk("ovr_valid", out_valid, 1);
    chk("ovr_hold", out_data, 8'h11);
    chk("ovr_pulses", n_ovr - c0, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;
    chk("ovr_drain", out_valid, 0);
    expect_frame("ovr", 8'h11, 1'b0, 1'b0);

    // reset in the middle of DATA
    drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b1); drive_bit(1'b1);
    rx_in = 1'b0; wait_ticks(5);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_valid", out_valid, 0);
    chk("mr_data", out_data, 0);
    rst_n = 1'b1;
    idle(32);
    send_frame(8'h3C, -1, 1, 1'b1); idle(20);
    expect_frame("mr", 8'h3C, 1'b0, 1'b0);

    // slow tick: 1 in 4 clocks
    tick_div = 4;
    idle(8);
    send_frame(8'hC3, -1, 1, 1'b1); idle(20);
    expect_frame("slow", 8'hC3, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
